branch_ctrl: RTL
================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter: ENTRIES, 16, number of BTB/BHT entries (power of two, 4..64).
REQ-002 Ports, clock and reset first:
  clk_i  in  1  single clock; all state on rising edge
  rst_ni  in  1  reset, asynchronous, active-low
  if_valid_i  in  1  IF-stage PC valid
  if_pc_i  in  32  IF-stage fetch PC
  pred_taken_o  out  1  prediction for if_pc_i
  pred_target_o  out  32  predicted next PC
  ex_valid_i  in  1  EX-stage instruction valid
  ex_is_br_i  in  1  EX instruction is a conditional branch
  ex_is_uncbr_i  in  1  EX instruction is JAL/JALR
  ex_pc_i  in  32  EX instruction PC
  ex_pred_taken_i  in  1  prediction carried down with the EX instruction
  ex_pred_target_i  in  32  predicted target carried down with it
  ex_true_taken_i  in  1  branch-unit resolved decision
  ex_target_i  in  32  resolved target address
  redirect_o  out  1  fetch redirect strobe
  redirect_pc_o  out  32  corrected fetch PC
  flush_o  out  1  squash IF/ID, ID/EX, EX/MEM pipeline entries
  br_count_o  out  32  resolved branch/jump count
  mispred_count_o  out  32  mispredict count

Function
REQ-003 Index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]; entry = {valid, tag, target[31:0], ctr[1:0]}.
REQ-004 Lookup is combinational: hit = entry valid and tag match; pred_taken_o = if_valid_i & hit & ctr[1].
REQ-005 pred_target_o = entry target when pred_taken_o, else if_pc_i + 4 (mod 2^32).
REQ-006 resolve = ex_valid_i & (ex_is_br_i | ex_is_uncbr_i) & state==IDLE.
REQ-007 mispredict = resolve & ((ex_pred_taken_i != ex_true_taken_i) | (ex_true_taken_i & ex_pred_target_i != ex_target_i)).
REQ-008 FSM states IDLE, REDIRECT; IDLE->REDIRECT on mispredict; REDIRECT->IDLE unconditionally after one cycle.
REQ-009 In REDIRECT, and only then: redirect_o=1, flush_o=1, redirect_pc_o = registered (ex_true_taken_i ? ex_target_i : ex_pc_i+4) captured at the mispredict edge; latency one cycle.
REQ-010 redirect_pc_o holds its last value outside REDIRECT; redirect_o, flush_o are 0 outside REDIRECT.
REQ-011 EX inputs are ignored during REDIRECT (instruction is wrong-path): no table update, no count.
REQ-012 Table update on resolve, written at the clock edge: hit -> ctr saturating +1 if taken, -1 if not; target <= ex_target_i if taken.
REQ-013 Miss and taken -> allocate: valid=1, tag, target=ex_target_i, ctr=2'b10; miss and not taken -> no write.
REQ-014 ex_is_uncbr_i resolve -> ctr forced to 2'b11 (hit or allocate).
REQ-015 Same-cycle lookup and update on the same index: lookup returns pre-update contents.
REQ-016 Counters saturate at 2'b00 and 2'b11; no wrap.
REQ-017 br_count_o increments on resolve; mispred_count_o increments on mispredict; both wrap 0xFFFF_FFFF -> 0.

Reset
REQ-018 rst_ni low asynchronously forces: state=IDLE, all valid=0, all ctr=2'b01, counts=0, redirect_pc_o=0, redirect_o=0, flush_o=0.
REQ-019 Reset asserted during REDIRECT aborts the redirect; no redirect_o pulse follows deassertion.
REQ-020 Tag/target storage need not be reset; valid=0 masks it.

Structure
REQ-021 Package bp_pkg holds ENTRIES default, IDX_W, TAG_W, ctr_t enum {SNT, WNT, WT, ST}, and the FSM state enum.
REQ-022 One sub-module, bp_sat_ctr: 2-bit saturating counter next-state function, instantiated in the update path.

Verification
REQ-023 After reset, if_pc_i=0x100, if_valid_i=1 -> pred_taken_o=0, pred_target_o=0x104.
REQ-024 EX br at 0x100, pred 0, true 1, target 0x200 -> next cycle redirect_o=1, flush_o=1, redirect_pc_o=0x200; then lookup 0x100 -> taken, 0x200; counts 1/1.
REQ-025 Same branch resolved taken x3 then not-taken x1 -> ctr 10->11->11->10, still predicts taken; no redirect on the correctly predicted taken resolves.
REQ-026 Mispredict in cycle N plus valid branch in EX at N+1 -> N+1 input ignored, br_count_o increments once only.
REQ-027 JAL at 0x300 with pred_target 0x400, true target 0x500 -> redirect to 0x500, entry ctr=11.
REQ-028 rst_ni low mid-REDIRECT -> redirect_o, flush_o 0 immediately; all lookups miss after release.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and sizing for the branch predictor: table geometry,
// 2-bit counter encoding and redirect FSM states.
package bp_pkg;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int TAG_W   = 32 - IDX_W - 2;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } bp_state_t;

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
module bp_sat_ctr
    import bp_pkg::*;
(
    input  ctr_t ctr_i,
    input  logic taken_i,
    output ctr_t ctr_o
);

    // step toward the resolved direction, holding at either end
    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != ST) begin
                ctr_o = ctr_t'(ctr_i + 2'b01);
            end else begin
                ctr_o = ST;
            end
        end else begin
            if (ctr_i != SNT) begin
                ctr_o = ctr_t'(ctr_i - 2'b01);
            end else begin
                ctr_o = SNT;
            end
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Direct-mapped BTB/BHT branch predictor with one-cycle mispredict
// redirect/flush and resolved-branch statistics.
module branch_ctrl #(
    parameter int ENTRIES = bp_pkg::ENTRIES
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        if_valid_i,
    input  logic [31:0] if_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        ex_valid_i,
    input  logic        ex_is_br_i,
    input  logic        ex_is_uncbr_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_pred_taken_i,
    input  logic [31:0] ex_pred_target_i,
    input  logic        ex_true_taken_i,
    input  logic [31:0] ex_target_i,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic [31:0] br_count_o,
    output logic [31:0] mispred_count_o
);
    import bp_pkg::*;

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = 32 - IDX_BITS - 2;

    logic                valid_q  [ENTRIES];
    ctr_t                ctr_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];

    bp_state_t   state_q;
    logic        redirect_q;
    logic        flush_q;
    logic [31:0] redirect_pc_q;
    logic [31:0] br_cnt_q;
    logic [31:0] mis_cnt_q;

    logic [IDX_BITS-1:0] if_idx_s, ex_idx_s;
    logic [TAG_BITS-1:0] if_tag_s, ex_tag_s;
    logic [1:0]          if_ctr_s;
    logic                if_hit_s, ex_hit_s;
    logic                resolve_s, mispredict_s;
    ctr_t                ex_ctr_nxt_s, ctr_d;

    assign if_idx_s = if_pc_i[IDX_BITS+1:2];
    assign if_tag_s = if_pc_i[31:IDX_BITS+2];
    assign ex_idx_s = ex_pc_i[IDX_BITS+1:2];
    assign ex_tag_s = ex_pc_i[31:IDX_BITS+2];

    // Lookup reads the table before any same-edge update lands
    assign if_ctr_s      = ctr_q[if_idx_s];
    assign if_hit_s      = valid_q[if_idx_s] && (tag_q[if_idx_s] == if_tag_s);
    assign pred_taken_o  = if_valid_i & if_hit_s & if_ctr_s[1];
    assign pred_target_o = pred_taken_o ? target_q[if_idx_s] : (if_pc_i + 32'd4);

    assign ex_hit_s     = valid_q[ex_idx_s] && (tag_q[ex_idx_s] == ex_tag_s);
    assign resolve_s    = ex_valid_i & (ex_is_br_i | ex_is_uncbr_i) & (state_q == IDLE);
    assign mispredict_s = resolve_s & ((ex_pred_taken_i != ex_true_taken_i) |
                          (ex_true_taken_i & (ex_pred_target_i != ex_target_i)));

    bp_sat_ctr u_sat_ctr (
        .ctr_i   (ctr_q[ex_idx_s]),
        .taken_i (ex_true_taken_i),
        .ctr_o   (ex_ctr_nxt_s)
    );

    // new counter value for the resolving entry: jumps pin strong, fresh entries start weak-taken
    always_comb begin
        ctr_d = ex_ctr_nxt_s;
        if (ex_is_uncbr_i) begin
            ctr_d = ST;
        end else if (!ex_hit_s) begin
            ctr_d = WT;
        end else begin
            ctr_d = ex_ctr_nxt_s;
        end
    end

    // valid bits and counters; a not-taken miss leaves the table alone
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= WNT;
            end
        end else if (resolve_s && (ex_hit_s || ex_true_taken_i)) begin
            valid_q[ex_idx_s] <= 1'b1;
            ctr_q[ex_idx_s]   <= ctr_d;
        end
    end

    // tag/target payload, masked by valid so it carries no reset
    always_ff @(posedge clk_i) begin
        if (resolve_s && ex_true_taken_i) begin
            tag_q[ex_idx_s]    <= ex_tag_s;
            target_q[ex_idx_s] <= ex_target_i;
        end
    end

    // redirect FSM with registered strobe, flush and corrected PC
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            redirect_q    <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mispredict_s) begin
                        state_q       <= REDIRECT;
                        redirect_q    <= 1'b1;
                        flush_q       <= 1'b1;
                        redirect_pc_q <= ex_true_taken_i ? ex_target_i : (ex_pc_i + 32'd4);
                    end else begin
                        redirect_q <= 1'b0;
                        flush_q    <= 1'b0;
                    end
                end
                REDIRECT: begin
                    state_q    <= IDLE;
                    redirect_q <= 1'b0;
                    flush_q    <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    redirect_q <= 1'b0;
                    flush_q    <= 1'b0;
                end
            endcase
        end
    end

    // resolved-branch and mispredict statistics, free-running wrap
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            br_cnt_q  <= 32'd0;
            mis_cnt_q <= 32'd0;
        end else begin
            if (resolve_s) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (mispredict_s) begin
                mis_cnt_q <= mis_cnt_q + 32'd1;
            end
        end
    end

    assign redirect_o      = redirect_q;
    assign flush_o         = flush_q;
    assign redirect_pc_o   = redirect_pc_q;
    assign br_count_o      = br_cnt_q;
    assign mispred_count_o = mis_cnt_q;

endmodule
